// File: rtl/bcd_year_loader.sv
// Iterative BCD-to-binary converter for the two-digit year field (reverse double-dabble, one shift per clock).
// Optional input range check is compiled in with `define BCD_RANGE_CHECK_EN.
module bcd_year_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] digit1_in,
  input  logic [3:0] digit0_in,
  output logic       busy,
  output logic       done,
  output logic [6:0] bin_out,
  output logic       err
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_reg, state_next;
  logic [14:0] s_reg, s_next;
  logic [14:0] s_shift, s_adj;
  logic [2:0]  cnt_reg, cnt_next;
  logic [6:0]  bin_reg, bin_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        bad_digit;

`ifdef BCD_RANGE_CHECK_EN
  assign bad_digit = (digit1_in > 4'd9) || (digit0_in > 4'd9);
`else
  // Without the check, err can never be set and stays a constant zero.
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      bin_reg   <= bin_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    bin_next   = bin_reg;
    done_next  = 1'b0;
    err_next   = err_reg;

    // Shift first, then correct each BCD nibble that now holds 8 or more.
    s_shift = {1'b0, s_reg[14:1]};
    s_adj   = s_shift;
    if (s_shift[14:11] >= 4'd8) s_adj[14:11] = s_shift[14:11] - 4'd3;
    if (s_shift[10:7]  >= 4'd8) s_adj[10:7]  = s_shift[10:7]  - 4'd3;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            err_next  = 1'b1;
            done_next = 1'b1;
          end else begin
            s_next     = {digit1_in, digit0_in, 7'b0};
            cnt_next   = 3'd0;
            err_next   = 1'b0;
            state_next = CONV;
          end
        end
      end
      CONV: begin
        s_next   = s_adj;
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd6) begin
          bin_next   = s_adj[6:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == CONV);
  assign done    = done_reg;
  assign bin_out = bin_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_bcd_year_loader.sv
// Scoreboard bench for bcd_year_loader: driver pushes expected {bin, err}, negedge monitor pops on done.
// Error-path tests run only when BCD_RANGE_CHECK_EN is defined.
module tb_bcd_year_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] digit1_in, digit0_in;
  logic       busy, done, err;
  logic [6:0] bin_out;

  bcd_year_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .digit1_in(digit1_in), .digit0_in(digit0_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int bin; int err; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   model_bin = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn done: bin_out=%0d err=%0d (model %0d/%0d)", bin_out, err, e.bin, e.err);
        chk("bin_out", int'(bin_out), e.bin);
        chk("err", int'(err), e.err);
      end
    end
  end

  function automatic bit is_bcd(input int d1, input int d0);
    return (d1 <= 9) && (d0 <= 9);
  endfunction

  // Reference model: a year is simply ten times the tens digit plus the units digit.
  function automatic void expect_req(input int d1, input int d0);
    exp_t e;
    if (is_bcd(d1, d0)) begin
      model_bin = 10 * d1 + d0;
      e.bin = model_bin; e.err = 0;
    end else begin
      e.bin = model_bin; e.err = 1;
    end
    exp_q.push_back(e);
  endfunction

  // From #1 after an edge, count edges until done is seen; also count busy cycles.
  task automatic wait_done(output int n, output int b);
    n = 0; b = 0;
    while (!done && n < 20) begin
      if (busy) b++;
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", n, -1);
  endtask

  task automatic req(input int d1, input int d0);
    int n, b;
    @(negedge clk);
    start = 1'b1; digit1_in = 4'(d1); digit0_in = 4'(d0);
    expect_req(d1, d0);
    @(posedge clk); #1;
    start = 1'b0;
    digit1_in = 4'($urandom); digit0_in = 4'($urandom);
    wait_done(n, b);
    chk("latency", n, is_bcd(d1, d0) ? 7 : 0);
    chk("busy_cycles", b, is_bcd(d1, d0) ? 7 : 0);
    @(posedge clk); #1;
    chk("done_width", int'(done), 0);
  endtask

  initial begin
    int n, b;
    reset = 1'b1; start = 1'b0; digit1_in = 4'd0; digit0_in = 4'd0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bin", int'(bin_out), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    req(9, 9);

    // Reset mid-conversion: outputs clear at once and the pending result never appears.
    @(negedge clk);
    start = 1'b1; digit1_in = 4'd5; digit0_in = 4'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_bin", int'(bin_out), 0);
    model_bin = 0;
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("midrst_bin_after", int'(bin_out), 0);

    req(0, 0); req(1, 6); req(4, 2); req(5, 9);

    // start held high: one conversion per 8 cycles; a 3,3 glitch mid-conversion is ignored.
    @(negedge clk);
    start = 1'b1; digit1_in = 4'd2; digit0_in = 4'd0;
    repeat (3) expect_req(2, 0);
    @(posedge clk); #1;
    wait_done(n, b);
    chk("held_first", n, 7);
    @(posedge clk); #1;
    digit1_in = 4'd3; digit0_in = 4'd3;
    @(posedge clk); #1;
    digit1_in = 4'd2; digit0_in = 4'd0;
    wait_done(n, b);
    chk("held_period", n + 2, 8);
    @(posedge clk); #1;
    wait_done(n, b);
    chk("held_period2", n + 1, 8);
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_stop", int'(busy), 0);

`ifdef BCD_RANGE_CHECK_EN
    req(9, 9);
    req(1, 10);
    chk("err_hold", int'(err), 1);
    chk("err_bin_hold", int'(bin_out), 99);
    @(negedge clk);
    start = 1'b1; digit1_in = 4'd0; digit0_in = 4'd7;
    expect_req(0, 7);
    @(posedge clk); #1 start = 1'b0;
    chk("err_clear_on_accept", int'(err), 0);
    wait_done(n, b);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) req(int'($urandom_range(15)), int'($urandom_range(15)));
`endif

    for (int d1 = 0; d1 < 10; d1++)
      for (int d0 = 0; d0 < 10; d0++)
        req(d1, d0);

    for (int i = 0; i < 20; i++) req(int'($urandom_range(9)), int'($urandom_range(9)));

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
